// File: rtl/hnf_tag_sram_ctl.sv
// -----------------------------------------------------------------------------
// hnf_tag_sram_ctl
//
// Request front-end for the HN-F tag SRAM. Registers tag read/write requests
// from the cache pipeline onto the SRAM loc_* inputs, tracks the SRAM read
// latency so returned tag lines come with a valid strobe and index, and
// (optionally) walks the whole array clearing every way before it serves
// traffic.
//
// Build option:
//   HNF_TAG_SRAM_INIT_EN  defined   -> clear walk after reset and on init_req
//                         undefined -> READY straight out of reset, no clears,
//                                      init_req ignored (FPGA / preloaded RAM)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_req        pulse: re-clear the whole tag array
//   req_valid/ready request handshake (req_ready is the only combinational out)
//   req_index       request index
//   req_rd          read all ways at req_index
//   req_wr_ways     per-way write enable
//   req_wr_cline    write data, common to all enabled ways
//   init_done       array cleared, controller serving traffic
//   rd_err          one-cycle pulse: read dropped from a combined rd+wr
//   loc_index_q, loc_rd_en_q, loc_wr_ways_q, loc_wr_cline_q  -> tag SRAM
//   rd_vld_q        SRAM read data (loc_rd_clines_q) valid this cycle
//   rd_index_q      index belonging to the returned lines
// -----------------------------------------------------------------------------
`ifndef LOC_INDEX_WIDTH
`define LOC_INDEX_WIDTH 4
`endif
`ifndef LOC_WAY_NUM
`define LOC_WAY_NUM 4
`endif
`ifndef LOC_CLINE_WIDTH
`define LOC_CLINE_WIDTH 12
`endif

module hnf_tag_sram_ctl #(
   parameter int INDEX_WIDTH = `LOC_INDEX_WIDTH,
   parameter int WAY_NUM     = `LOC_WAY_NUM,
   parameter int CLINE_WIDTH = `LOC_CLINE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   init_req,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [INDEX_WIDTH-1:0] req_index,
   input  logic                   req_rd,
   input  logic [WAY_NUM-1:0]     req_wr_ways,
   input  logic [CLINE_WIDTH-1:0] req_wr_cline,
   output logic                   init_done,
   output logic                   rd_err,
   output logic [INDEX_WIDTH-1:0] loc_index_q,
   output logic                   loc_rd_en_q,
   output logic [WAY_NUM-1:0]     loc_wr_ways_q,
   output logic [CLINE_WIDTH-1:0] loc_wr_cline_q,
   output logic                   rd_vld_q,
   output logic [INDEX_WIDTH-1:0] rd_index_q
);

   typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

   state_e                 state_q;
   logic [INDEX_WIDTH-1:0] cnt_q;
   logic                   vld_p0_q;
   logic                   vld_p1_q;
   logic [INDEX_WIDTH-1:0] idx_p0_q;
   logic [INDEX_WIDTH-1:0] idx_p1_q;

   logic accept;
   logic combined;
   logic rd_issue;

`ifdef HNF_TAG_SRAM_INIT_EN
   assign req_ready = (state_q == ST_READY) & ~init_req;
`else
   logic init_req_unused;
   assign init_req_unused = init_req;
   assign req_ready       = (state_q == ST_READY);
`endif

   assign accept   = req_valid & req_ready;
   // A read combined with a write is dropped: the write wins, rd_err flags it.
   assign combined = req_rd & (|req_wr_ways);
   assign rd_issue = accept & req_rd & ~combined;

   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef HNF_TAG_SRAM_INIT_EN
         state_q <= ST_INIT;
`else
         state_q <= ST_READY;
`endif
         cnt_q          <= '0;
         loc_index_q    <= '0;
         loc_rd_en_q    <= 1'b0;
         loc_wr_ways_q  <= '0;
         loc_wr_cline_q <= '0;
         init_done      <= 1'b0;
         rd_err         <= 1'b0;
         vld_p0_q       <= 1'b0;
         vld_p1_q       <= 1'b0;
         rd_vld_q       <= 1'b0;
         idx_p0_q       <= '0;
         idx_p1_q       <= '0;
         rd_index_q     <= '0;
      end else begin
         rd_err <= accept & combined;

         // p0: command presented on loc_* to the SRAM
         vld_p0_q <= rd_issue;
         idx_p0_q <= req_index;
         // p1: SRAM array access
         vld_p1_q <= vld_p0_q;
         idx_p1_q <= idx_p0_q;
         // p2: SRAM output register, lines valid alongside rd_vld_q
         rd_vld_q   <= vld_p1_q;
         rd_index_q <= idx_p1_q;

         case (state_q)
            ST_INIT: begin
               loc_index_q    <= cnt_q;
               loc_rd_en_q    <= 1'b0;
               loc_wr_ways_q  <= '1;
               loc_wr_cline_q <= '0;
               cnt_q          <= cnt_q + 1'b1;
               // Last index written this edge; counter wraps to 0 by itself.
               if (cnt_q == {INDEX_WIDTH{1'b1}}) begin
                  state_q   <= ST_READY;
                  init_done <= 1'b1;
               end
            end
            ST_READY: begin
               if (accept) begin
                  loc_index_q    <= req_index;
                  loc_rd_en_q    <= req_rd & ~combined;
                  loc_wr_ways_q  <= req_wr_ways;
                  loc_wr_cline_q <= req_wr_cline;
               end else begin
                  // Index and write data hold so no X reaches the SRAM pins.
                  loc_rd_en_q   <= 1'b0;
                  loc_wr_ways_q <= '0;
               end
`ifdef HNF_TAG_SRAM_INIT_EN
               if (init_req) begin
                  state_q   <= ST_INIT;
                  cnt_q     <= '0;
                  init_done <= 1'b0;
               end
`else
               init_done <= 1'b1;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hnf_tag_sram_ctl.sv
module tb_hnf_tag_sram_ctl;

   localparam int IW    = 4;
   localparam int WN    = 4;
   localparam int CW    = 12;
   localparam int DEPTH = 16;

`ifdef HNF_TAG_SRAM_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif
   // Cycles from walk start until traffic is accepted / init_done is seen.
   localparam int READY_DLY = INIT_EN ? DEPTH : 0;
   localparam int DONE_DLY  = INIT_EN ? DEPTH : 1;

   logic          clk;
   logic          rst;
   logic          init_req;
   logic          req_valid;
   logic          req_ready;
   logic [IW-1:0] req_index;
   logic          req_rd;
   logic [WN-1:0] req_wr_ways;
   logic [CW-1:0] req_wr_cline;
   logic          init_done;
   logic          rd_err;
   logic [IW-1:0] loc_index_q;
   logic          loc_rd_en_q;
   logic [WN-1:0] loc_wr_ways_q;
   logic [CW-1:0] loc_wr_cline_q;
   logic          rd_vld_q;
   logic [IW-1:0] rd_index_q;

   hnf_tag_sram_ctl #(
      .INDEX_WIDTH(IW),
      .WAY_NUM    (WN),
      .CLINE_WIDTH(CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .init_req      (init_req),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_index     (req_index),
      .req_rd        (req_rd),
      .req_wr_ways   (req_wr_ways),
      .req_wr_cline  (req_wr_cline),
      .init_done     (init_done),
      .rd_err        (rd_err),
      .loc_index_q   (loc_index_q),
      .loc_rd_en_q   (loc_rd_en_q),
      .loc_wr_ways_q (loc_wr_ways_q),
      .loc_wr_cline_q(loc_wr_cline_q),
      .rd_vld_q      (rd_vld_q),
      .rd_index_q    (rd_index_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tag SRAM with registered output, driven by the DUT's loc_* pins.
   logic [WN*CW-1:0] smem [DEPTH];
   logic [WN*CW-1:0] raw_q;
   logic [WN*CW-1:0] rd_clines;
   bit               smem_rdy;

   always @(posedge clk) begin
      if (!smem_rdy) begin
         for (int i = 0; i < DEPTH; i++) smem[i] <= '0;
         smem_rdy <= 1'b1;
      end else begin
         for (int k = 0; k < WN; k++)
            if (loc_wr_ways_q[k]) smem[loc_index_q][k*CW +: CW] <= loc_wr_cline_q;
         if (loc_rd_en_q) raw_q <= smem[loc_index_q];
      end
      rd_clines <= raw_q;
   end

   // ---------------- reference model state ----------------
   typedef struct {
      int               due;
      logic [IW-1:0]    idx;
      logic [WN*CW-1:0] data;
   } rd_t;

   rd_t              rq[$];
   logic [WN*CW-1:0] refmem [DEPTH];
   int               cyc;
   int               w;        // cycle in which the current walk / READY period began
   bit               started;
   logic [IW-1:0]    e_idx;
   bit               e_rd;
   logic [WN-1:0]    e_ways;
   logic [CW-1:0]    e_cline;
   bit               e_err;

   int nvec;
   int nfail;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < DEPTH; i++) refmem[i] = '0;
   endtask

   // One clock cycle: drive inputs, check outputs of this cycle, predict next.
   task automatic tick(input bit r, input bit ir, input bit v, input bit rd,
                       input logic [IW-1:0] idx, input logic [WN-1:0] ways,
                       input logic [CW-1:0] cl);
      bit mready, acc, comb, evld;
      rst = r; init_req = ir; req_valid = v; req_rd = rd;
      req_index = idx; req_wr_ways = ways; req_wr_cline = cl;
      @(negedge clk);
      mready = (cyc >= w + READY_DLY) && !(INIT_EN && ir);
      if (started) begin
         chk("req_ready", req_ready, mready);
         chk("init_done", init_done, cyc >= w + DONE_DLY);
         chk("loc_index", loc_index_q, e_idx);
         chk("loc_rd_en", loc_rd_en_q, e_rd);
         chk("loc_wr_ways", loc_wr_ways_q, e_ways);
         chk("loc_wr_cline", loc_wr_cline_q, e_cline);
         chk("rd_err", rd_err, e_err);
         evld = (rq.size() > 0) && (rq[0].due == cyc);
         chk("rd_vld", rd_vld_q, evld);
         if (evld) begin
            chk("rd_index", rd_index_q, rq[0].idx);
            chk("rd_clines", rd_clines, rq[0].data);
            void'(rq.pop_front());
         end
      end
      if (r) begin
         started = 1'b1;
         w       = cyc + 1;
         rq.delete();
         e_idx = '0; e_rd = 1'b0; e_ways = '0; e_cline = '0; e_err = 1'b0;
         if (INIT_EN) clear_ref();
      end else begin
         acc   = v && mready;
         comb  = rd && (ways != '0);
         e_err = acc && comb;
         if (INIT_EN && cyc >= w && cyc < w + DEPTH) begin
            e_idx = IW'(cyc - w); e_rd = 1'b0; e_ways = '1; e_cline = '0;
         end else if (acc) begin
            e_idx = idx; e_rd = rd && !comb; e_ways = ways; e_cline = cl;
            if (rd && !comb) rq.push_back('{cyc + 3, idx, refmem[idx]});
            for (int k = 0; k < WN; k++)
               if (ways[k]) refmem[idx][k*CW +: CW] = cl;
         end else begin
            e_rd = 1'b0; e_ways = '0;
         end
         if (INIT_EN && ir && cyc >= w + DEPTH) begin
            w = cyc + 1;
            clear_ref();
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit               v;
      bit               rd;
      logic [IW-1:0]    idx;
      logic [WN-1:0]    ways;
      logic [CW-1:0]    cl;
      bit               e_rd_en;
      logic [WN-1:0]    e_ways;
      bit               e_err;
      bit               e_vld;
      logic [WN*CW-1:0] e_data;
   } vec_t;

   vec_t tbl[7];

   initial begin
      nvec = 0; nfail = 0; cyc = 0; w = 0; started = 1'b0;
      clear_ref();
      rst = 1'b1; init_req = 1'b0; req_valid = 1'b0; req_rd = 1'b0;
      req_index = '0; req_wr_ways = '0; req_wr_cline = '0;

      //          v  rd idx    ways     cl       rd_en ways    err vld data
      tbl[0] = '{1, 0, 4'd5, 4'b0010, 12'hABC, 0, 4'b0010, 0, 0, 48'h0};
      tbl[1] = '{1, 1, 4'd5, 4'b0000, 12'h000, 1, 4'b0000, 0, 1, 48'h000_000_ABC_000};
      tbl[2] = '{1, 1, 4'd7, 4'b0001, 12'h123, 0, 4'b0001, 1, 0, 48'h0};
      tbl[3] = '{1, 1, 4'd7, 4'b0000, 12'h000, 1, 4'b0000, 0, 1, 48'h000_000_000_123};
      tbl[4] = '{1, 0, 4'd5, 4'b1001, 12'h5A5, 0, 4'b1001, 0, 0, 48'h0};
      tbl[5] = '{1, 1, 4'd5, 4'b0000, 12'h000, 1, 4'b0000, 0, 1, 48'h5A5_000_ABC_5A5};
      tbl[6] = '{0, 1, 4'd3, 4'b0000, 12'h000, 0, 4'b0000, 0, 0, 48'h0};

      @(posedge clk); #1;

      // Reset, then the clear walk (or immediate READY).
      tick(1, 0, 0, 0, '0, '0, '0);
      tick(1, 0, 0, 0, '0, '0, '0);
      repeat (20) idle();

      for (int i = 0; i < 7; i++) begin
         tick(0, 0, tbl[i].v, tbl[i].rd, tbl[i].idx, tbl[i].ways, tbl[i].cl);
         chk("tbl_rd_en", loc_rd_en_q, tbl[i].e_rd_en);
         chk("tbl_wr_ways", loc_wr_ways_q, tbl[i].e_ways);
         chk("tbl_rd_err", rd_err, tbl[i].e_err);
         if (tbl[i].v) chk("tbl_index", loc_index_q, tbl[i].idx);
         idle();
         idle();
         chk("tbl_rd_vld", rd_vld_q, tbl[i].e_vld);
         if (tbl[i].e_vld) begin
            chk("tbl_rd_index", rd_index_q, tbl[i].idx);
            chk("tbl_rd_clines", rd_clines, tbl[i].e_data);
         end
         idle();
      end

      // Back-to-back reads 1,2,3.
      tick(0, 0, 1, 1, 4'd1, '0, '0);
      tick(0, 0, 1, 1, 4'd2, '0, '0);
      tick(0, 0, 1, 1, 4'd3, '0, '0);
      for (int i = 1; i <= 3; i++) begin
         chk("b2b_vld", rd_vld_q, 1'b1);
         chk("b2b_index", rd_index_q, i);
         idle();
      end
      chk("b2b_vld_end", rd_vld_q, 1'b0);
      repeat (3) idle();

      // Read, then init_req on the next cycle.
      tick(0, 0, 1, 1, 4'd5, '0, '0);
      tick(0, 1, 1, 1, 4'd6, '0, '0);
      chk("ir_done_drop", init_done, !INIT_EN);
      idle();
      chk("ir_rd_vld", rd_vld_q, 1'b1);
      chk("ir_rd_index", rd_index_q, 4'd5);
      chk("ir_rd_clines", rd_clines, 48'h5A5_000_ABC_5A5);
      repeat (20) idle();
      tick(0, 0, 1, 1, 4'd5, '0, '0);
      idle();
      idle();
      chk("post_init_vld", rd_vld_q, 1'b1);
      chk("post_init_data", rd_clines, INIT_EN ? 48'h0 : 48'h5A5_000_ABC_5A5);
      repeat (3) idle();

      // Reset in the middle of a walk (counter 7).
      tick(0, 1, 0, 0, '0, '0, '0);
      repeat (7) idle();
      tick(1, 0, 0, 0, '0, '0, '0);
      chk("rst_wr_ways", loc_wr_ways_q, '0);
      chk("rst_index", loc_index_q, '0);
      chk("rst_done", init_done, 1'b0);
      repeat (20) idle();

      // Reset while a read is in flight: its strobe is discarded.
      tick(0, 0, 1, 1, 4'd3, '0, '0);
      tick(1, 0, 0, 0, '0, '0, '0);
      idle();
      chk("rst_rd_vld", rd_vld_q, 1'b0);
      repeat (20) idle();

      // Randomised traffic with occasional init_req and reset.
      for (int n = 0; n < 3000; n++) begin
         logic [WN-1:0] ways;
         ways = ($urandom_range(0, 1) == 0) ? '0 : WN'($urandom);
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              IW'($urandom), ways, CW'($urandom));
      end
      repeat (5) idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
